// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage and its MEM/WB register.
// Holds the FSM state type, the write-back control bit positions and the stall counter width.
package mem_access_stage_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

    localparam int STALL_CNT_W = 16;

    // Data memory is word-addressed, so the byte offset is always cleared.
    function automatic logic [31:0] wordAlign(input logic [31:0] byteAddr);
        return byteAddr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// MEM/WB pipeline register: loads the stage results when not stalled, and
// injects a write-back bubble while the stage is frozen.
module mem_wb_reg
    import mem_access_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        bubble_i,
    input  logic [1:0]  wb_i,
    input  logic [31:0] read_data_i,
    input  logic [31:0] alu_result_i,
    input  logic [4:0]  rd_i,
    output logic [1:0]  wb_o,
    output logic [31:0] read_data_o,
    output logic [31:0] alu_result_o,
    output logic [4:0]  rd_o
);

    logic [1:0]  wb_q,        wb_d;
    logic [31:0] read_data_q, read_data_d;
    logic [31:0] alu_result_q, alu_result_d;
    logic [4:0]  rd_q,        rd_d;

    // A bubble only clears the control bits; the datapath fields keep their last values.
    always_comb begin
        wb_d         = wb_q;
        read_data_d  = read_data_q;
        alu_result_d = alu_result_q;
        rd_d         = rd_q;
        if (bubble_i) begin
            wb_d = 2'b00;
        end else if (load_i) begin
            wb_d         = wb_i;
            read_data_d  = read_data_i;
            alu_result_d = alu_result_i;
            rd_d         = rd_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_q         <= 2'b00;
            read_data_q  <= 32'h0;
            alu_result_q <= 32'h0;
            rd_q         <= 5'h0;
        end else begin
            wb_q         <= wb_d;
            read_data_q  <= read_data_d;
            alu_result_q <= alu_result_d;
            rd_q         <= rd_d;
        end
    end

    assign wb_o         = wb_q;
    assign read_data_o  = read_data_q;
    assign alu_result_o = alu_result_q;
    assign rd_o         = rd_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: issues loads/stores to data memory, stalls the pipeline until the
// memory acknowledges, and feeds the MEM/WB register. Counts stalled cycles.
module mem_access_stage
    import mem_access_stage_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [1:0]             WB_i,
    input  logic                   MemRead_i,
    input  logic                   MemWrite_i,
    input  logic [31:0]            Address_i,
    input  logic [31:0]            Write_data_i,
    input  logic [4:0]             rd_i,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [31:0]            dmem_addr_o,
    output logic [31:0]            dmem_wdata_o,
    input  logic                   dmem_ack_i,
    input  logic [31:0]            dmem_rdata_i,
    output logic                   stall_o,
    output logic [1:0]             WB_o,
    output logic [31:0]            Read_data_o,
    output logic [31:0]            ALUResult_o,
    output logic [4:0]             rd_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    state_e                 state_q, state_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   access;
    logic                   isRead;
    logic [31:0]            loadData;

    assign access = MemRead_i | MemWrite_i;
    // Write wins when both requests are raised, so such an access never returns load data.
    assign isRead = MemRead_i & ~MemWrite_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (dmem_req_o && !dmem_ack_i) state_d = WAIT;
            WAIT: if (dmem_ack_i)                state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dmem_req_o   = (state_q == WAIT) || ((state_q == IDLE) && access);
        stall_o      = dmem_req_o & ~dmem_ack_i;
        dmem_we_o    = MemWrite_i;
        dmem_addr_o  = wordAlign(Address_i);
        dmem_wdata_o = Write_data_i;
    end

    // An ack with no outstanding request is not a load completion.
    assign loadData = (dmem_req_o && dmem_ack_i && isRead) ? dmem_rdata_i : 32'h0;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o = stall_cnt_q;

    mem_wb_reg u_mem_wb_reg (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (~stall_o),
        .bubble_i     (stall_o),
        .wb_i         (WB_i),
        .read_data_i  (loadData),
        .alu_result_i (Address_i),
        .rd_i         (rd_i),
        .wb_o         (WB_o),
        .read_data_o  (Read_data_o),
        .alu_result_o (ALUResult_o),
        .rd_o         (rd_o)
    );

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have ports, clock and reset first:
 clk_i  in  1  sole clock, rising edge;
 rst_i  in  1  reset, asynchronous, active-high;
 WB_i  in  2  write-back control from EX/MEM, [1]=RegWrite, [0]=MemtoReg;
 MemRead_i  in  1  load request;
 MemWrite_i  in  1  store request;
 Address_i  in  32  ALU result / byte address;
 Write_data_i  in  32  store data;
 rd_i  in  5  destination register;
 dmem_req_o  out  1  memory request;
 dmem_we_o  out  1  1=write, 0=read;
 dmem_addr_o  out  32  word-aligned address;
 dmem_wdata_o  out  32  store data;
 dmem_ack_i  in  1  memory completion, one cycle per request;
 dmem_rdata_i  in  32  load data, valid with ack;
 stall_o  out  1  freeze request to hazard unit;
 WB_o  out  2  registered write-back control;
 Read_data_o  out  32  registered load data;
 ALUResult_o  out  32  registered Address_i;
 rd_o  out  5  registered rd_i;
 stall_cnt_o  out  16  saturating stall-cycle counter.
REQ-002 SHALL use one clock; reset SHALL be asynchronous and active-high, on ports clk_i and rst_i.

Function
REQ-003 access SHALL be defined as MemRead_i | MemWrite_i.
REQ-004 FSM SHALL have exactly two states: IDLE and WAIT.
REQ-005 dmem_req_o SHALL be (IDLE & access) | WAIT, combinationally.
REQ-006 dmem_we_o SHALL equal MemWrite_i; when both MemRead_i and MemWrite_i are set, write SHALL take priority.
REQ-007 dmem_addr_o SHALL be {Address_i[31:2],2'b00}; dmem_wdata_o SHALL equal Write_data_i.
REQ-008 stall_o SHALL be dmem_req_o & ~dmem_ack_i, combinationally; a zero-wait ack SHALL complete the access in the issuing cycle with no stall.
REQ-009 IDLE->WAIT SHALL occur when dmem_req_o & ~dmem_ack_i; WAIT->IDLE SHALL occur on dmem_ack_i; all other cases SHALL hold state.
REQ-010 upstream inputs SHALL be treated as stable while stall_o=1, because the hazard unit freezes EX/MEM.
REQ-011 on a clock edge with stall_o=0:
 WB_o<=WB_i, ALUResult_o<=Address_i, rd_o<=rd_i;
 Read_data_o<=dmem_rdata_i for a read with ack, otherwise 0.
REQ-012 on a clock edge with stall_o=1, WB_o SHALL be set to 2'b00 (bubble) and the other registered outputs SHALL hold.
REQ-013 load-to-use latency SHALL be one clock edge after the ack cycle.
REQ-014 dmem_ack_i in IDLE with no access SHALL be ignored.
REQ-015 stall_cnt_o SHALL increment on every edge where stall_o=1 and SHALL saturate at 16'hFFFF.

Reset
REQ-016 rst_i SHALL, asynchronously, force:
 state=IDLE;
 WB_o=0, Read_data_o=0, ALUResult_o=0, rd_o=0;
 stall_cnt_o=0.
REQ-017 reset asserted in WAIT SHALL abandon the access; dmem_req_o SHALL drop in the same cycle unless a new access is present, and a late ack SHALL be ignored.

Structure
REQ-018 a shared package SHALL hold:
 state enum {IDLE,WAIT};
 constants WB_REGWRITE=1, WB_MEMTOREG=0;
 STALL_CNT_W=16.
REQ-019 the MEM/WB output register SHALL be one sub-module, mem_wb_reg, with load and bubble inputs; the FSM and counter SHALL stay in the top.

Verification
REQ-020 load, Address_i=0x00000013, ack same cycle, rdata=0xDEADBEEF -> dmem_addr_o=0x10, stall_o=0, next edge Read_data_o=0xDEADBEEF, WB_o=WB_i.
REQ-021 store with ack after 3 cycles -> stall_o=1 for 3 cycles, WB_o=00 for 3 edges, stall_cnt_o=3, then WB_o=WB_i and Read_data_o=0.
REQ-022 MemRead_i=MemWrite_i=1 -> dmem_we_o=1, Read_data_o=0 after completion.
REQ-023 rst_i pulsed in WAIT -> state IDLE, all outputs 0, a following ack produces no output change.
REQ-024 continuous stall for 70000 cycles -> stall_cnt_o holds at 0xFFFF.
